// File: rtl/matmul_sequencer.sv
// matmul_sequencer: streams in two NxN byte matrices (A then B, row-major),
// issues one row/column pair at a time to an external dot-product engine,
// collects the NxN results and streams C back out row-major.
// Optional build macro MATMUL_SEQ_TIMEOUT_EN adds a per-request response
// timeout that substitutes 0 for the missing element and sets a sticky err.
module matmul_sequencer #(
  parameter int N       = 3,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [7:0]     in_data,
  output logic           in_ready,
  output logic           out_valid,
  output logic [7:0]     out_data,
  input  logic           out_ready,
  output logic [N*8-1:0] dp_row,
  output logic [N*8-1:0] dp_col,
  output logic           dp_valid,
  input  logic [7:0]     dp_result,
  input  logic           dp_result_valid,
  output logic           busy,
  output logic           err
);

  localparam int NN = N * N;
  localparam int IW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);
  localparam logic [IW-1:0] LAST_J   = IW'(N - 1);
  localparam logic [IW-1:0] ROW_STEP = IW'(N);

  typedef enum logic [2:0] {LOAD_A, LOAD_B, ISSUE, WAIT, UNLOAD} state_t;

  state_t        state_q, state_d;
  // Flat element index: load position, current (i,j) result slot, or unload position.
  logic [IW-1:0] cnt_q, cnt_d;
  // i*N for the current row and j for the current column, kept separately so the
  // operand muxes need no multiplier.
  logic [IW-1:0] row_base_q, row_base_d;
  logic [IW-1:0] j_q, j_d;

  logic [7:0] a_q [NN];
  logic [7:0] b_q [NN];
  logic [7:0] c_q [NN];
  logic       a_we, b_we, c_we;
  logic [7:0] c_wdata;
  logic       accept;

`ifdef MATMUL_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;
  logic          expire;

  // Timeout fires on the TIMEOUT-th WAIT cycle after the request.
  assign expire = (timer_q == TW'(TIMEOUT - 1));
  assign err    = err_q;

  // Timer and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end
`else
  assign err = 1'b0;
`endif

  // State and counter registers; storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD_A;
      cnt_q      <= '0;
      row_base_q <= '0;
      j_q        <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      row_base_q <= row_base_d;
      j_q        <= j_d;
    end
  end

  // Operand and result storage writes.
  always_ff @(posedge clk) begin
    if (a_we) a_q[cnt_q] <= in_data;
    if (b_we) b_q[cnt_q] <= in_data;
    if (c_we) c_q[cnt_q] <= c_wdata;
  end

  // Operand vectors for the current (i,j); they only move when a result is accepted.
  for (genvar gi = 0; gi < N; gi++) begin : g_dp
    assign dp_row[gi*8 +: 8] = a_q[row_base_q + IW'(gi)];
    assign dp_col[gi*8 +: 8] = b_q[j_q + IW'(gi * N)];
  end

  assign in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign out_valid = (state_q == UNLOAD);
  assign out_data  = c_q[cnt_q];
  assign dp_valid  = (state_q == ISSUE);
  assign busy      = (state_q != LOAD_A);

  // Next-state, counter and write-enable logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    row_base_d = row_base_q;
    j_d        = j_q;
    a_we       = 1'b0;
    b_we       = 1'b0;
    c_we       = 1'b0;
    c_wdata    = dp_result;
`ifdef MATMUL_SEQ_TIMEOUT_EN
    timer_d    = timer_q;
    err_d      = err_q;
    accept     = dp_result_valid || expire;
`else
    accept     = dp_result_valid;
`endif
    case (state_q)
      LOAD_A: begin
        if (in_valid) begin
          a_we = 1'b1;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = LOAD_B;
          end else begin
            cnt_d = cnt_q + IW'(1);
          end
        end
      end
      LOAD_B: begin
        if (in_valid) begin
          b_we = 1'b1;
          if (cnt_q == LAST_IDX) begin
            cnt_d      = '0;
            row_base_d = '0;
            j_d        = '0;
            state_d    = ISSUE;
          end else begin
            cnt_d = cnt_q + IW'(1);
          end
        end
      end
      ISSUE: begin
`ifdef MATMUL_SEQ_TIMEOUT_EN
        timer_d = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
`ifdef MATMUL_SEQ_TIMEOUT_EN
        timer_d = timer_q + TW'(1);
        // A result landing on the expiry cycle takes priority over the timeout.
        if (!dp_result_valid) begin
          c_wdata = 8'd0;
          if (expire) err_d = 1'b1;
        end
`endif
        if (accept) begin
          c_we = 1'b1;
          if (cnt_q == LAST_IDX) begin
            cnt_d      = '0;
            row_base_d = '0;
            j_d        = '0;
            state_d    = UNLOAD;
          end else begin
            cnt_d   = cnt_q + IW'(1);
            state_d = ISSUE;
            if (j_q == LAST_J) begin
              j_d        = '0;
              row_base_d = row_base_q + ROW_STEP;
            end else begin
              j_d = j_q + IW'(1);
            end
          end
        end
      end
      UNLOAD: begin
        if (out_ready) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = LOAD_A;
          end else begin
            cnt_d = cnt_q + IW'(1);
          end
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

endmodule

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 3, meaning the matrix dimension (NxN operands and result).
REQ-002 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum number of cycles to wait for a dot-product result.
REQ-003 The block SHALL have port clk, input, 1, meaning the clock, all logic on the rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning the reset, synchronous and active-high.
REQ-005 The block SHALL have ports in_valid (input, 1), in_data (input, 8) and in_ready (output, 1), meaning the operand element stream: A row-major, then B row-major.
REQ-006 The block SHALL have ports out_valid (output, 1), out_data (output, 8) and out_ready (input, 1), meaning the result C stream, row-major.
REQ-007 The block SHALL have port dp_row, output, N x 8, meaning row i of A, where element k is A[i][k].
REQ-008 The block SHALL have port dp_col, output, N x 8, meaning column j of B, where element k is B[k][j].
REQ-009 The block SHALL have port dp_valid, output, 1, meaning a one-cycle request pulse to the dot-product engine.
REQ-010 The block SHALL have ports dp_result (input, 8) and dp_result_valid (input, 1), meaning the engine's result and its one-cycle valid pulse.
REQ-011 The block SHALL have port busy, output, 1, meaning high in every state except LOAD_A.
REQ-012 The block SHALL have port err, output, 1, meaning a sticky timeout flag (see Configuration).

Function
REQ-013 The FSM SHALL have states LOAD_A, LOAD_B, ISSUE, WAIT and UNLOAD.
REQ-014 An element SHALL transfer on in_valid && in_ready, and in_ready SHALL be 1 only in LOAD_A and LOAD_B.
REQ-015 LOAD_A SHALL store N*N elements into A, then go to LOAD_B; LOAD_B SHALL store N*N elements into B, then go to ISSUE.
REQ-016 ISSUE SHALL drive dp_row/dp_col for the current (i,j), pulse dp_valid for exactly one cycle, and go to WAIT the next cycle.
REQ-017 dp_row/dp_col SHALL hold stable from the dp_valid cycle until the result is accepted.
REQ-018 WAIT SHALL write dp_result into C[i][j] on the first dp_result_valid, then advance j; on j wrap (N-1 to 0) it SHALL advance i.
REQ-019 After accepting the result for (N-1,N-1), WAIT SHALL go to UNLOAD; otherwise it SHALL go back to ISSUE.
REQ-020 dp_result_valid SHALL be ignored outside WAIT, and at most one request SHALL be outstanding.
REQ-021 The block SHALL store results as 8-bit values exactly as returned, with no widening or saturation.
REQ-022 UNLOAD SHALL present C elements row-major with out_valid=1, and the element SHALL advance only on out_valid && out_ready.
REQ-023 out_data SHALL hold stable while out_ready=0.
REQ-024 After the N*N-th output transfer, the FSM SHALL go to LOAD_A on the next cycle with out_valid=0.
REQ-025 Minimum latency per C element SHALL be 1 cycle (ISSUE) plus the engine latency plus 1 cycle (WAIT accept).
REQ-026 A new operand set SHALL be accepted only after UNLOAD completes.

Reset
REQ-027 rst SHALL force the FSM to LOAD_A and clear all counters.
REQ-028 rst SHALL force in_ready=1, out_valid=0, dp_valid=0, busy=0 and err=0.
REQ-029 rst asserted mid-operation SHALL abandon the operation, ignore any later stale dp_result_valid, and not clear the A, B or C storage.

Configuration
REQ-030 Macro MATMUL_SEQ_TIMEOUT_EN defined: WAIT SHALL count cycles after dp_valid, and after TIMEOUT cycles without dp_result_valid it SHALL write 0 to C[i][j], set err=1, and advance as in REQ-018.
REQ-031 err SHALL stay 1 until rst.
REQ-032 If dp_result_valid arrives in the expiry cycle, the result SHALL win and err SHALL stay unchanged.
REQ-033 Macro MATMUL_SEQ_TIMEOUT_EN undefined: WAIT SHALL wait indefinitely, err SHALL be constant 0, and no timeout counter SHALL exist.

Verification
REQ-034 Identity case: N=3, bench engine with 2-cycle latency, A=identity, B=1..9 -> C stream 1,2,...,9, err=0.
REQ-035 Wrap case: A all 10, B all 10 -> every C element is 44 (300 mod 256).
REQ-036 Backpressure case: out_ready toggled 1,0,0,1 during UNLOAD -> no element dropped or duplicated, out_data stable while stalled.
REQ-037 Reset case: rst asserted during WAIT with the engine result arriving 1 cycle later -> FSM in LOAD_A, result ignored, in_ready=1, next full run correct.
REQ-038 Timeout case (macro defined): engine never responds for (0,1) -> C[0][1]=0, err=1 after 15 WAIT cycles, other elements correct; result arriving on the expiry cycle -> err=0.
REQ-039 Gap case: in_valid gaps between elements and dp_result_valid pulsed during LOAD_B -> C unaffected.
